// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - fetch_state_t : fetch FSM states
//   - id_ctl_t      : IF/ID register update command
//   - skid_ctl_t    : skid buffer update command
//   - NOP_INSTR     : canonical bubble word (addi x0,x0,0)
//   - OP_*          : major opcodes shared with the main decoder
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    ID_HOLD       = 2'd0,
    ID_LOAD_FETCH = 2'd1,
    ID_LOAD_SKID  = 2'd2,
    ID_BUBBLE     = 2'd3
  } id_ctl_t;

  typedef enum logic [1:0] {
    SK_HOLD  = 2'd0,
    SK_LOAD  = 2'd1,
    SK_CLEAR = 2'd2
  } skid_ctl_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with a one-entry skid buffer.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_ctl              IF/ID command: hold, load fetched word, load skid, bubble
//   skid_ctl            skid command: hold, load fetched word, clear
//   fetch_instr/pc      word just returned by memory and its address
//   instr_d, pc_d,
//   pcplus4_d, valid_d  IF/ID outputs towards decode (bubble: NOP, 0, 0, 0)
module if_id_reg import fetch_pkg::*; #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BUBBLE_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  id_ctl_t         id_ctl,
  input  skid_ctl_t       skid_ctl,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            skid_valid;

  // Skid buffer: parks the word that returned while decode was stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_instr <= BUBBLE_INSTR;
      skid_pc    <= ZERO;
      skid_valid <= 1'b0;
    end else begin
      case (skid_ctl)
        SK_LOAD: begin
          skid_instr <= fetch_instr;
          skid_pc    <= fetch_pc;
          skid_valid <= 1'b1;
        end
        SK_CLEAR: begin
          skid_instr <= BUBBLE_INSTR;
          skid_pc    <= ZERO;
          skid_valid <= 1'b0;
        end
        default: begin
          skid_instr <= skid_instr;
          skid_pc    <= skid_pc;
          skid_valid <= skid_valid;
        end
      endcase
    end
  end

  // IF/ID register; pc+4 is computed on load so the link value is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d   <= BUBBLE_INSTR;
      pc_d      <= ZERO;
      pcplus4_d <= ZERO;
      valid_d   <= 1'b0;
    end else begin
      case (id_ctl)
        ID_LOAD_FETCH: begin
          instr_d   <= fetch_instr;
          pc_d      <= fetch_pc;
          pcplus4_d <= fetch_pc + PC_STEP;
          valid_d   <= 1'b1;
        end
        ID_LOAD_SKID: begin
          // An empty skid degenerates into a bubble rather than a stale word.
          if (skid_valid) begin
            instr_d   <= skid_instr;
            pc_d      <= skid_pc;
            pcplus4_d <= skid_pc + PC_STEP;
            valid_d   <= 1'b1;
          end else begin
            instr_d   <= BUBBLE_INSTR;
            pc_d      <= ZERO;
            pcplus4_d <= ZERO;
            valid_d   <= 1'b0;
          end
        end
        ID_BUBBLE: begin
          instr_d   <= BUBBLE_INSTR;
          pc_d      <= ZERO;
          pcplus4_d <= ZERO;
          valid_d   <= 1'b0;
        end
        default: begin
          instr_d   <= instr_d;
          pc_d      <= pc_d;
          pcplus4_d <= pcplus4_d;
          valid_d   <= valid_d;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding the main decoder.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall, flush              hold / squash requests from hazard logic
//   redirect, redirect_pc     taken branch/JAL/JALR and its target
//   imem_req, imem_addr       fetch request; address held while waiting
//   imem_ready, imem_rdata    response handshake and fetched word
//   instr_d, op_d, pc_d,
//   pcplus4_d, valid_d        IF/ID contents presented to decode
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [6:0]      op_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);
  import fetch_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(32'd3));

  fetch_state_t    state;
  fetch_state_t    state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] drain_addr_nx;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_tgt;
  id_ctl_t         id_ctl;
  skid_ctl_t       skid_ctl;

  assign pc_inc       = pc + PC_STEP;
  assign redirect_tgt = redirect_pc & ALIGN_MASK;

  // While draining an abandoned request the old address must stay on the bus.
  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign op_d      = instr_d[6:0];

  // FSM, PC and drain-address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_BOOT;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      drain_addr <= drain_addr_nx;
    end
  end

  // Next-state, next-PC and IF/ID / skid commands.
  // Default for IF/ID: a stalled decoder keeps its word; otherwise it has
  // consumed it and receives a bubble unless a new word is loaded below.
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    skid_ctl      = SK_HOLD;
    if (stall) begin
      id_ctl = ID_HOLD;
    end else begin
      id_ctl = ID_BUBBLE;
    end

    case (state)
      S_BOOT: begin
        state_nx = S_FETCH;
      end

      S_FETCH: begin
        if (redirect) begin
          pc_nx    = redirect_tgt;
          skid_ctl = SK_CLEAR;
          id_ctl   = ID_BUBBLE;
          if (imem_ready) begin
            state_nx = S_FETCH;
          end else begin
            // Request still in flight: remember its address and wait it out.
            state_nx      = S_DRAIN;
            drain_addr_nx = pc;
          end
        end else if (flush) begin
          // The returning word is squashed; with stall also set the PC is not
          // advanced so the word is fetched again after the stall.
          id_ctl = ID_BUBBLE;
          if (imem_ready && !stall) begin
            pc_nx = pc_inc;
          end else begin
            pc_nx = pc;
          end
        end else if (imem_ready) begin
          pc_nx = pc_inc;
          if (stall) begin
            skid_ctl = SK_LOAD;
            state_nx = S_HOLD;
          end else begin
            id_ctl = ID_LOAD_FETCH;
          end
        end else begin
          state_nx = S_FETCH;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_nx    = redirect_tgt;
          skid_ctl = SK_CLEAR;
          id_ctl   = ID_BUBBLE;
          state_nx = S_FETCH;
        end else if (flush) begin
          id_ctl = ID_BUBBLE;
          if (!stall) begin
            skid_ctl = SK_CLEAR;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_HOLD;
          end
        end else if (!stall) begin
          id_ctl   = ID_LOAD_SKID;
          skid_ctl = SK_CLEAR;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_HOLD;
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          pc_nx    = redirect_tgt;
          skid_ctl = SK_CLEAR;
          id_ctl   = ID_BUBBLE;
        end else if (flush) begin
          id_ctl = ID_BUBBLE;
        end else begin
          pc_nx = pc;
        end
        // Data for the abandoned request is never loaded anywhere.
        if (imem_ready) begin
          state_nx = S_FETCH;
        end else begin
          state_nx = S_DRAIN;
        end
      end

      default: begin
        state_nx = S_BOOT;
        pc_nx    = RESET_PC;
        skid_ctl = SK_CLEAR;
        id_ctl   = ID_BUBBLE;
      end
    endcase
  end

  if_id_reg #(
    .XLEN        (XLEN),
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .id_ctl     (id_ctl),
    .skid_ctl   (skid_ctl),
    .fetch_instr(imem_rdata),
    .fetch_pc   (pc),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pcplus4_d  (pcplus4_d),
    .valid_d    (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stimulus, checked every
// cycle against a behavioural model of the fetch stage and a wait-state memory.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_d;
  logic [6:0]  op_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .op_d(op_d), .pc_d(pc_d),
    .pcplus4_d(pcplus4_d), .valid_d(valid_d)
  );

  // ---------------- behavioural model ----------------
  bit          m_boot;        // first cycle after reset: no request yet
  logic [31:0] m_pc;          // next address to fetch
  bit          m_drain;       // an abandoned request is still outstanding
  logic [31:0] m_drain_addr;
  logic [31:0] q_instr[$];    // word parked while decode was stalled
  logic [31:0] q_pc[$];
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  bit          m_valid;
  bit          chk_en = 1'b0;

  // memory: wait states before each response
  int wait_cfg  = 0;
  bit wait_rand = 1'b0;
  int wait_left = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F11;
  endfunction

  function automatic bit exp_req();
    return !m_boot && (q_instr.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  function automatic int next_wait();
    return wait_rand ? int'($urandom_range(0, 3)) : wait_cfg;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_valid = 1'b0;
    m_instr = NOP_INSTR;
    m_pcd   = 32'd0;
  endtask

  task automatic load(input logic [31:0] w, input logic [31:0] p);
    m_valid = 1'b1;
    m_instr = w;
    m_pcd   = p;
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = 32'd0;
    m_drain = 1'b0;
    m_drain_addr = 32'd0;
    q_instr.delete();
    q_pc.delete();
    bubble();
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit          req;
    bit          rdy;
    logic [31:0] addr;
    req  = exp_req();
    addr = exp_addr();
    rdy  = imem_ready;
    if (req) begin
      if (rdy) wait_left = next_wait();
      else if (wait_left > 0) wait_left--;
    end
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      q_instr.delete();
      q_pc.delete();
      bubble();
      m_drain_addr = addr;
      m_drain = req && !rdy;
    end else if (m_drain) begin
      if (rdy) m_drain = 1'b0;
      if (flush || !stall) bubble();
    end else if (q_instr.size() != 0) begin
      if (flush) begin
        bubble();
        if (!stall) begin
          q_instr.delete();
          q_pc.delete();
        end
      end else if (!stall) begin
        load(q_instr[0], q_pc[0]);
        q_instr.delete();
        q_pc.delete();
      end
    end else begin
      if (flush) begin
        bubble();
        if (rdy && !stall) m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        if (stall) begin
          q_instr.push_back(imem_rdata);
          q_pc.push_back(m_pc);
        end else begin
          load(imem_rdata, m_pc);
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        bubble();
      end
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model.
  task automatic cycle(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
    stall       = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = exp_req() && (wait_left == 0);
    imem_rdata  = imem_ready ? mem_word(exp_addr()) : 32'hDEAD_BEEF;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic finish_reset();
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_left = next_wait();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    finish_reset();
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("imem_req", 32'(imem_req), 32'(exp_req()));
      if (exp_req()) check32("imem_addr", imem_addr, exp_addr());
      check32("valid_d", 32'(valid_d), 32'(m_valid));
      check32("instr_d", instr_d, m_instr);
      check32("op_d", 32'(op_d), 32'(m_instr[6:0]));
      check32("pc_d", pc_d, m_valid ? m_pcd : 32'd0);
      check32("pcplus4_d", pcplus4_d, m_valid ? (m_pcd + 32'd4) : 32'd0);
    end
  end

  initial begin
    model_reset();
    do_reset();
    chk_en = 1'b1;

    // reset values
    check32("rst_req", 32'(imem_req), 32'd0);
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_valid", 32'(valid_d), 32'd0);
    check32("rst_instr", instr_d, 32'h0000_0013);

    // zero-wait streaming
    cycle(0, 0, 0, 32'd0);
    check32("boot_req", 32'(imem_req), 32'd1);
    check32("boot_addr", imem_addr, 32'h0);
    check32("boot_valid", 32'(valid_d), 32'd0);
    cycle(0, 0, 0, 32'd0);
    check32("first_valid", 32'(valid_d), 32'd1);
    check32("first_pc", pc_d, 32'h0);
    check32("first_pc4", pcplus4_d, 32'h4);
    check32("first_instr", instr_d, mem_word(32'h0));
    check32("addr_4", imem_addr, 32'h4);
    cycle(0, 0, 0, 32'd0);
    check32("second_pc", pc_d, 32'h4);
    check32("addr_8", imem_addr, 32'h8);

    // stall for three cycles with a zero-wait memory
    repeat (3) begin
      cycle(1, 0, 0, 32'd0);
      check32("stall_hold_pc", pc_d, 32'h4);
      check32("stall_req", 32'(imem_req), 32'd0);
    end
    cycle(0, 0, 0, 32'd0);
    check32("skid_pc", pc_d, 32'h8);
    check32("skid_instr", instr_d, mem_word(32'h8));
    check32("after_skid_addr", imem_addr, 32'hC);
    cycle(0, 0, 0, 32'd0);
    check32("after_skid_pc", pc_d, 32'hC);

    // redirect while the memory answers in the same cycle
    cycle(0, 0, 1, 32'h0000_0102);
    check32("redir_valid", 32'(valid_d), 32'd0);
    check32("redir_instr", instr_d, 32'h0000_0013);
    check32("redir_op", 32'(op_d), 32'(OP_I));
    check32("redir_addr", imem_addr, 32'h100);
    cycle(0, 0, 0, 32'd0);
    check32("redir_pc", pc_d, 32'h100);

    // three wait states, redirect in the first wait cycle
    wait_cfg = 3;
    wait_left = 3;
    cycle(0, 0, 1, 32'h0000_0200);
    check32("drain_addr0", imem_addr, 32'h104);
    repeat (2) cycle(0, 0, 0, 32'd0);
    check32("drain_addr2", imem_addr, 32'h104);
    cycle(0, 0, 0, 32'd0);
    check32("drain_drop", 32'(valid_d), 32'd0);
    check32("drain_next", imem_addr, 32'h200);
    repeat (4) cycle(0, 0, 0, 32'd0);
    check32("drain_pc", pc_d, 32'h200);
    check32("drain_instr", instr_d, mem_word(32'h200));

    // flush together with stall
    wait_cfg = 0;
    wait_left = 0;
    repeat (2) cycle(1, 1, 0, 32'd0);
    check32("fs_valid", 32'(valid_d), 32'd0);
    check32("fs_instr", instr_d, 32'h0000_0013);
    check32("fs_addr", imem_addr, 32'h204);
    cycle(0, 0, 0, 32'd0);
    check32("fs_resume", pc_d, 32'h204);

    // wrap-around at the top of the address space
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    check32("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 32'd0);
    check32("wrap_pc", pc_d, 32'hFFFF_FFFC);
    check32("wrap_pc4", pcplus4_d, 32'h0);
    check32("wrap_next", imem_addr, 32'h0);
    cycle(0, 0, 0, 32'd0);
    check32("wrap_pc0", pc_d, 32'h0);

    // reset asserted in the middle of a wait
    wait_left = 3;
    cycle(0, 0, 0, 32'd0);
    rst = 1'b1;
    model_reset();
    #1;
    check32("mid_rst_req", 32'(imem_req), 32'd0);
    check32("mid_rst_addr", imem_addr, 32'h0);
    check32("mid_rst_valid", 32'(valid_d), 32'd0);
    check32("mid_rst_instr", instr_d, 32'h0000_0013);
    check32("mid_rst_pc", pc_d, 32'h0);
    check32("mid_rst_pc4", pcplus4_d, 32'h0);
    finish_reset();

    // randomized traffic
    wait_rand = 1'b1;
    wait_left = next_wait();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 7, tgt);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
